// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter: the master drives count controls,
// the slave (the counter) returns the registered count and terminal-count pulse.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  count, tc
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output count, tc
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Synchronous up/down modulo-MODULUS counter with clock-enable prescaler, clear/load
// and registered terminal-count pulse. Define COUNTER_SAT_EN for saturating mode.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mod_updown_counter_if.slave  if_s
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] C_MAX      = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    C_PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre_cnt;
  logic             r_tc;

  logic             w_pre_last;
  logic             w_at_top;
  logic             w_at_bot;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_pre_last     = (r_pre_cnt == C_PRE_LAST);
  assign w_at_top       = (r_count == C_MAX);
  assign w_at_bot       = (r_count == '0);
  assign w_load_clamped = (32'(if_s.load_val) >= 32'(MODULUS)) ? C_MAX : if_s.load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_pre_cnt <= '0;
      r_tc      <= 1'b0;
    end else if (if_s.clear) begin
      r_count   <= '0;
      r_pre_cnt <= '0;
      r_tc      <= 1'b0;
    end else if (if_s.load) begin
      r_count   <= w_load_clamped;
      r_pre_cnt <= '0;
      r_tc      <= 1'b0;
    end else if (if_s.en && !w_pre_last) begin
      r_pre_cnt <= r_pre_cnt + PW'(1);
      r_tc      <= 1'b0;
    end else if (if_s.en) begin
      r_pre_cnt <= '0;
      // Boundary steps raise tc: a wrap normally, a blocked step in saturating mode
      if (if_s.up_dn) begin
        if (w_at_top) begin
`ifdef COUNTER_SAT_EN
          r_count <= C_MAX;
`else
          r_count <= '0;
`endif
          r_tc    <= 1'b1;
        end else begin
          r_count <= r_count + WIDTH'(1);
          r_tc    <= 1'b0;
        end
      end else begin
        if (w_at_bot) begin
`ifdef COUNTER_SAT_EN
          r_count <= '0;
`else
          r_count <= C_MAX;
`endif
          r_tc    <= 1'b1;
        end else begin
          r_count <= r_count - WIDTH'(1);
          r_tc    <= 1'b0;
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign if_s.count = r_count;
  assign if_s.tc    = r_tc;

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down modulo-N counter; successor to the 4-bit ripple counter.
- All state changes on one clock edge, so there is no ripple skew.
- Adds width/modulus generality, a clock-enable prescaler, synchronous clear/load, direction control and a terminal-count pulse.
- Used as a timebase/event counter and as a cascadable digit counter (tc of one stage drives en of the next).

Parameters:
- WIDTH, 4, counter bit width (1..16).
- MODULUS, 16, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2^WIDTH.
- PRESCALE, 1, enabled cycles per count step (1..256); 1 = step on every enabled cycle.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; advances the prescaler.
- up_dn  input  1  1 = count up, 0 = count down; sampled on step cycles.
- clear  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  load value.
- count  output  WIDTH  registered count value.
- tc  output  1  registered terminal-count pulse.

Behaviour:
- Reset (reset=1, asynchronous): count=0, tc=0, internal prescaler pre_cnt=0. These hold for as long as reset is high. First update on the first rising clk edge after reset falls.
- Priority per edge: reset > clear > load > step. Lower-priority requests in the same cycle are ignored.
- clear=1: count=0, pre_cnt=0, tc=0 next cycle.
- load=1: count=load_val, pre_cnt=0, tc=0.
  - If load_val >= MODULUS, count=MODULUS-1 (clamp).
- Prescaler:
  - en=0: pre_cnt and count hold; tc=0.
  - en=1 and pre_cnt<PRESCALE-1: pre_cnt+1, count holds.
  - en=1 and pre_cnt==PRESCALE-1: pre_cnt=0 and a step occurs.
  - With PRESCALE=1, every en cycle is a step.
- Step, up (up_dn=1): count<MODULUS-1 -> count+1; count==MODULUS-1 -> count=0 (wrap).
- Step, down (up_dn=0): count>0 -> count-1; count==0 -> count=MODULUS-1 (wrap).
- tc:
  - High for exactly one cycle, the cycle in which count first shows the wrapped value.
  - Low in all other cycles, including after load or clear to a boundary value.
  - Consecutive wraps (MODULUS=2, PRESCALE=1, en held) give tc high continuously.
- up_dn changes between steps: no effect on pre_cnt; the direction used is the value sampled on the step cycle.
- Latency: one clk from step cycle to count/tc update. No combinational path from inputs to outputs.
- All arithmetic is WIDTH bits, unsigned. Values >= MODULUS are never reachable except via reset-free X states, which the bench does not exercise.

Optional Feature:
- Macro: COUNTER_SAT_EN.
- Defined: saturating mode.
  - An up step at MODULUS-1 holds MODULUS-1; a down step at 0 holds 0.
  - tc pulses for one cycle on every such blocked step.
  - Non-boundary steps, load, clear and the prescaler are unchanged.
- Undefined: wrap-around behaviour as above. No saturation logic is synthesised.

Test Plan:
- WIDTH=4, MODULUS=10, PRESCALE=1; reset pulse, then en=1, up_dn=1 for 12 cycles -> count 0,1..9,0,1; tc high only in the cycle count=0 after 9.
- Same config, load=1, load_val=2, then up_dn=0 for 4 steps -> count 2,1,0,9,8; tc high in the cycle count=9. load_val=12 -> count=9 with tc=0.
- PRESCALE=3, MODULUS=16, en=1 with en=0 for 2 cycles mid-stream -> count increments every 3rd enabled cycle; pre_cnt holds during en=0.
- clear and load asserted together with count=7 -> count=0 next cycle; load ignored; tc=0.
- reset asserted asynchronously mid-count at count=5 between edges -> count=0, tc=0 immediately. After release, the first step gives count=1.
- COUNTER_SAT_EN defined, MODULUS=10, count=9, up steps x3 -> count stays 9; tc high for 3 consecutive cycles; a down step then gives count=8.
